// File: rtl/sic_issue_sched_pkg.sv
// Shared types and configuration for the sub-SIC issue scheduler, plus a
// generic round-robin picker that other arbiters in the SIC can reuse.
package sic_issue_sched_pkg;

  // Scheduler configuration: default slot count and issue queue depth
  localparam int SIC_NUM_SIC_DFLT = 4;
  localparam int SIC_Q_DEPTH      = 2;

  // Widest request vector rr_pick can scan
  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = $clog2(RR_MAX);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  tag;
  } sic_packet_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t r;
    int       j;
    // NOTE: every variable gets a value before any conditional path, so the
    // logic built from this stays purely combinational with no inferred latch.
    r = '0;
    j = 0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (!r.found && req[RR_IDX_W'(j)]) begin
          r.found = 1'b1;
          r.idx   = RR_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sic_issue_sched_if.sv
// Issue-side and slot-side handshake bundle of the scheduler. The master view
// belongs to the decode stage plus the slot array; the slave view to the scheduler.
interface sic_issue_sched_if
  import sic_issue_sched_pkg::*;
#(
  parameter int NUM_SIC = SIC_NUM_SIC_DFLT
) ();

  logic               issue_valid;
  sic_packet_t        issue_pkt;
  logic               issue_ready;
  logic               flush;
  logic [NUM_SIC-1:0] sub_req;
  logic [NUM_SIC-1:0] sub_valid;
  sic_packet_t        sub_pkt;

  modport master (
    output issue_valid, issue_pkt, flush, sub_req,
    input  issue_ready, sub_valid, sub_pkt
  );

  modport slave (
    input  issue_valid, issue_pkt, flush, sub_req,
    output issue_ready, sub_valid, sub_pkt
  );

endinterface

// File: rtl/sic_pkt_fifo2.sv
// Two-entry circular packet FIFO with 1-bit head/tail pointers, an occupancy
// count and a synchronous clear. Callers never push when full or pop when empty.
module sic_pkt_fifo2
  import sic_issue_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  sic_packet_t push_pkt,
  output sic_packet_t head_pkt,
  output logic [1:0]  count
);

  sic_packet_t mem [SIC_Q_DEPTH];
  logic        head;
  logic        tail;

  // NOTE: payload storage is deliberately not reset; count gates every read,
  // so clearing it would only add reset fan-out to a wide datapath.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_pkt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_pkt = mem[head];

endmodule

// File: rtl/sic_issue_sched.sv
// Issue scheduler: queues issued packets and hands each one, as a registered
// one-cycle strobe, to an idle ready sub-SIC slot chosen round-robin.
module sic_issue_sched
  import sic_issue_sched_pkg::*;
#(
  parameter int NUM_SIC = SIC_NUM_SIC_DFLT,
  parameter int PTR_W   = $clog2(NUM_SIC),
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  sic_issue_sched_if.slave bus,
  output logic [1:0]       q_count,
  output logic [CNT_W-1:0] issued_cnt
);

  logic [NUM_SIC-1:0] sub_valid_q;
  sic_packet_t        sub_pkt_q;
  sic_packet_t        head_pkt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   rr_next;
  logic [NUM_SIC-1:0] elig;
  rr_pick_t           pick;
  logic               push;
  logic               grant;

  // Ready depends only on registered occupancy, never on sub_req or flush
  assign bus.issue_ready = (q_count != 2'(SIC_Q_DEPTH));
  assign push            = bus.issue_valid && bus.issue_ready && !bus.flush;

  // A slot strobed this cycle may still show its stale ready bit; skip it
  assign elig = bus.sub_req & ~sub_valid_q;

  always_comb begin
    pick = rr_pick(RR_MAX'(elig), RR_IDX_W'(rr_ptr), NUM_SIC);
  end

  assign grant   = (q_count != 2'd0) && pick.found && !bus.flush;
  assign win_idx = PTR_W'(pick.idx);
  assign rr_next = (win_idx == PTR_W'(NUM_SIC - 1)) ? '0 : win_idx + PTR_W'(1);

  sic_pkt_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.flush),
    .push     (push),
    .pop      (grant),
    .push_pkt (bus.issue_pkt),
    .head_pkt (head_pkt),
    .count    (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_valid_q <= '0;
      sub_pkt_q   <= '0;
      rr_ptr      <= '0;
      issued_cnt  <= '0;
    end else begin
      sub_valid_q <= '0;
      if (grant) begin
        sub_valid_q[win_idx] <= 1'b1;
        sub_pkt_q            <= head_pkt;
        rr_ptr               <= rr_next;
        issued_cnt           <= issued_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sub_valid = sub_valid_q;
  assign bus.sub_pkt   = sub_pkt_q;

endmodule
